// File: rtl/glyph_pkg.sv
// Shared glyph codes and scroll state type for the seven-segment message path.
package glyph_pkg;

  localparam int GLYPH_W = 5;

  localparam logic [GLYPH_W-1:0] GLYPH_0     = 5'd0;
  localparam logic [GLYPH_W-1:0] GLYPH_1     = 5'd1;
  localparam logic [GLYPH_W-1:0] GLYPH_2     = 5'd2;
  localparam logic [GLYPH_W-1:0] GLYPH_3     = 5'd3;
  localparam logic [GLYPH_W-1:0] GLYPH_4     = 5'd4;
  localparam logic [GLYPH_W-1:0] GLYPH_5     = 5'd5;
  localparam logic [GLYPH_W-1:0] GLYPH_6     = 5'd6;
  localparam logic [GLYPH_W-1:0] GLYPH_7     = 5'd7;
  localparam logic [GLYPH_W-1:0] GLYPH_8     = 5'd8;
  localparam logic [GLYPH_W-1:0] GLYPH_9     = 5'd9;
  localparam logic [GLYPH_W-1:0] GLYPH_DASH  = 5'd26;
  localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 5'd31;

  // Four blank digits, the display word shown whenever nothing is scrolling.
  localparam logic [4*GLYPH_W-1:0] NUM_BLANK = {4{GLYPH_BLANK}};

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SCROLL = 1'b1
  } scroll_state_e;

endpackage

// File: rtl/scroll_tick.sv
// Scroll-rate prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
// Held at zero while clr is high so each scroll starts with a full period.
module scroll_tick #(
  parameter int TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running prescaler, cleared synchronously by reset or clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_LAST) & ~clr;

endmodule

// File: rtl/glyph_scroller.sv
// Message scroller feeding the 4-digit seven-segment driver.
// Glyphs enter at the rightmost digit (num[4:0]) and move left one digit per
// scroll step; four trailing blank steps clear the display at the end.
// Build option: GLYPH_SCROLLER_LOOP_EN repeats the message (with its
// 4-blank gap) until stop or reset, pulsing done once per pass.
module glyph_scroller
  import glyph_pkg::*;
#(
  parameter int MSG_LEN  = 16,
  parameter int TICK_DIV = 12500000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [GLYPH_W-1:0]         wr_data,
  input  logic [$clog2(MSG_LEN):0]   msg_len,
  input  logic                       start,
  input  logic                       stop,
  output logic                       busy,
  output logic                       done,
  output logic [4*GLYPH_W-1:0]       num
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(MSG_LEN + 4) + 1;

  scroll_state_e      state;
  logic [GLYPH_W-1:0] mem [MSG_LEN];
  logic [LW-1:0]      len;
  logic [LW-1:0]      len_clamped;
  logic [SW-1:0]      step;
  logic [GLYPH_W-1:0] glyph;
  logic               last_step;
  logic               tick;
  logic               tick_clr;

  // Prescaler only runs while scrolling; an accepted start finds it at zero.
  assign tick_clr = (state == ST_IDLE) | stop;

  scroll_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  assign len_clamped = (msg_len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len;

  // Steps past the message body shift in blanks; the index is in range
  // whenever step < len because len never exceeds MSG_LEN.
  assign glyph     = (step < SW'(len)) ? mem[step[AW-1:0]] : GLYPH_BLANK;
  assign last_step = (step == SW'(len) + SW'(3));

  // Message buffer: one write port, read via glyph above. Not reset, and a
  // same-edge write is seen only by later steps (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Scroll sequencer: accepts start in IDLE, shifts one glyph per tick, and
  // ends (or wraps) after len+4 steps. stop overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      num   <= NUM_BLANK;
      busy  <= 1'b0;
      done  <= 1'b0;
      len   <= '0;
      step  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        num   <= NUM_BLANK;
        busy  <= 1'b0;
        step  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              len   <= len_clamped;
              step  <= '0;
              busy  <= 1'b1;
              state <= ST_SCROLL;
            end
          end
          ST_SCROLL: begin
            if (tick) begin
              num <= {num[3*GLYPH_W-1:0], glyph};
              if (last_step) begin
                done <= 1'b1;
                step <= '0;
`ifdef GLYPH_SCROLLER_LOOP_EN
`else
                busy  <= 1'b0;
                state <= ST_IDLE;
`endif
              end else begin
                step <= step + SW'(1);
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glyph_scroller.sv
// Self-checking bench for glyph_scroller (MSG_LEN=16, TICK_DIV=4).
// Reference: the display shows the last four glyphs of a stream made of the
// message followed by four blanks (repeating when GLYPH_SCROLLER_LOOP_EN).
module tb_glyph_scroller;

  localparam int ML = 16;
  localparam int TD = 4;
  localparam logic [19:0] BLANK20 = 20'hFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [4:0]  wr_data = '0;
  logic [4:0]  msg_len = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy;
  logic        done;
  logic [19:0] num;

  glyph_scroller #(
    .MSG_LEN  (ML),
    .TICK_DIV (TD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .msg_len (msg_len),
    .start   (start),
    .stop    (stop),
    .busy    (busy),
    .done    (done),
    .num     (num)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [4:0] ref_mem [ML];
  logic [4:0] snap [ML];

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_glyph(input int a, input logic [4:0] d);
    wr_en = 1'b1;
    wr_addr = a[3:0];
    wr_data = d;
    cyc();
    wr_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Display after k steps: glyphs k-4..k-1 of the stream, oldest leftmost.
  function automatic logic [19:0] model_num(input int k, input int len, input bit loopm);
    logic [19:0] r;
    r = BLANK20;
    for (int d = 0; d < 4; d++) begin
      int i;
      logic [4:0] g;
      i = k - 4 + d;
      g = 5'd31;
      if (i >= 0) begin
        int p;
        p = loopm ? (i % (len + 4)) : i;
        if (p < len) g = snap[p];
      end
      r = {r[14:0], g};
    end
    return r;
  endfunction

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      cyc();
      check({tag, "_num"}, num, BLANK20);
      check({tag, "_busy"}, 20'(busy), 20'(0));
      check({tag, "_done"}, 20'(done), 20'(0));
    end
  endtask

  task automatic accept(input int req_len, output int len);
    len = (req_len > ML) ? ML : req_len;
    snap = ref_mem;
    msg_len = req_len[4:0];
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("accept_busy", 20'(busy), 20'(1));
    check("accept_done", 20'(done), 20'(0));
    check("accept_num", num, model_num(0, len, 1'b0));
  endtask

  // One-shot scroll; optional stop after a given step and optional write to
  // the address read by its step, issued in that very step cycle.
  task automatic run_scroll(input int req_len, input int stop_after,
                            input int coll_addr, input logic [4:0] coll_data);
    int len;
    int cyc_total;
    accept(req_len, len);
    cyc_total = TD * (len + 4);
    for (int j = 1; j <= cyc_total; j++) begin
      if (stop_after > 0 && j == TD * stop_after + 1) begin
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("stop_num", num, BLANK20);
        check("stop_busy", 20'(busy), 20'(0));
        check("stop_done", 20'(done), 20'(0));
        check_idle("after_stop", 2 * TD);
        return;
      end
      if (coll_addr >= 0 && j == TD * (coll_addr + 1)) begin
        wr_en = 1'b1;
        wr_addr = coll_addr[3:0];
        wr_data = coll_data;
      end
      start = (j < cyc_total) && ($urandom_range(0, 3) == 0);
      cyc();
      start = 1'b0;
      if (wr_en) begin
        wr_en = 1'b0;
        ref_mem[coll_addr] = coll_data;
      end
      check($sformatf("num_L%0d_j%0d", len, j), num, model_num(j / TD, len, 1'b0));
      check($sformatf("busy_L%0d_j%0d", len, j), 20'(busy), 20'(j < cyc_total));
      check($sformatf("done_L%0d_j%0d", len, j), 20'(done), 20'(j == cyc_total));
    end
    cyc();
    check("done_cleared", 20'(done), 20'(0));
    check("end_busy", 20'(busy), 20'(0));
    check("end_num", num, BLANK20);
  endtask

  // Looping scroll: run the given number of passes plus a little, then stop.
  task automatic run_loop(input int req_len, input int passes);
    int len;
    int period;
    accept(req_len, len);
    period = TD * (len + 4);
    for (int j = 1; j <= period * passes + TD; j++) begin
      start = ($urandom_range(0, 3) == 0);
      cyc();
      start = 1'b0;
      check($sformatf("lnum_L%0d_j%0d", len, j), num, model_num(j / TD, len, 1'b1));
      check($sformatf("lbusy_L%0d_j%0d", len, j), 20'(busy), 20'(1));
      check($sformatf("ldone_L%0d_j%0d", len, j), 20'(done), 20'(j % period == 0));
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("lstop_num", num, BLANK20);
    check("lstop_busy", 20'(busy), 20'(0));
    check_idle("lafter_stop", 2 * TD);
  endtask

  initial begin
    int len_dummy;
    rst_n = 1'b0;
    repeat (3) cyc();
    check("rst_num", num, BLANK20);
    check("rst_busy", 20'(busy), 20'(0));
    check("rst_done", 20'(done), 20'(0));
    rst_n = 1'b1;
    cyc();

    for (int a = 0; a < ML; a++) write_glyph(a, 5'($urandom_range(0, 31)));
    write_glyph(0, 5'd1);
    write_glyph(1, 5'd2);
    write_glyph(2, 5'd3);

    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    check("ss_busy", 20'(busy), 20'(0));
    check_idle("ss_idle", 2);

`ifdef GLYPH_SCROLLER_LOOP_EN
    run_loop(2, 3);
    run_loop(0, 2);
    run_loop(20, 2);
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < ML; a++) write_glyph(a, 5'($urandom_range(0, 31)));
      run_loop($urandom_range(0, 31), 2);
    end
`else
    run_scroll(3, 0, -1, 5'd0);
    run_scroll(3, 2, -1, 5'd0);
    run_scroll(0, 0, -1, 5'd0);
    run_scroll(20, 0, -1, 5'd0);
    run_scroll(3, 0, 1, 5'd9);
    run_scroll(3, 0, -1, 5'd0);
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < ML; a++)
        if ($urandom_range(0, 1) == 1) write_glyph(a, 5'($urandom_range(0, 31)));
      run_scroll($urandom_range(0, 31), 0, -1, 5'd0);
    end
    run_scroll($urandom_range(1, 16), 1, -1, 5'd0);
`endif

    // reset mid-scroll aborts without done
    accept(5, len_dummy);
    repeat (10) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("mrst_num", num, BLANK20);
    check("mrst_busy", 20'(busy), 20'(0));
    check("mrst_done", 20'(done), 20'(0));
    check_idle("mrst_idle", 6 * TD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/glyph_scroller.md
Name: glyph_scroller

Overview:
- Upstream feeder for the 4-digit seven-segment driver.
- Holds a message of up to MSG_LEN 5-bit glyph codes and scrolls it right-to-left across the four digits, one position per scroll tick.
- Drives the packed 20-bit glyph word consumed by the display driver: num[19:15] is the leftmost digit, num[4:0] the rightmost.
- Glyph code 31 = blank; codes follow the team glyph table.

Parameters:
- MSG_LEN, 16, message buffer depth in glyphs (power of two, 2..32).
- TICK_DIV, 12500000, clk cycles per scroll step (≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  $clog2(MSG_LEN)  buffer write address.
- wr_data  input  5  glyph code to write.
- msg_len  input  $clog2(MSG_LEN)+1  number of glyphs to scroll, sampled on start.
- start  input  1  begin a scroll, level-sampled in IDLE.
- stop  input  1  abort the scroll and blank the display.
- busy  output  1  high while scrolling.
- done  output  1  one-cycle pulse when a scroll completes.
- num  output  20  four packed glyph codes to the display driver.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - num=20'hFFFFF (all blank); busy=0; done=0; state=IDLE; prescaler=0; step counter=0.
  - Buffer contents are not reset.
  - Reset mid-scroll aborts immediately; done is not pulsed.
- States: IDLE, SCROLL.
- IDLE:
  - num holds its last value (all blank after reset or stop).
  - start=1 and stop=0: latch len=min(msg_len,MSG_LEN), clear prescaler and step counter, set busy=1 next cycle, go to SCROLL.
- SCROLL:
  - The prescaler counts 0..TICK_DIV-1; the cycle it wraps is a step. The first step occurs TICK_DIV cycles after start is accepted.
  - Each step: num <= {num[14:0], g}, where g = buf[step] if step < len, else 5'd31. Step counter then increments.
  - Total steps = len+4. The last step leaves num all blank.
  - On the last step: state to IDLE, busy=0 and done=1 in the same next cycle. done lasts exactly one cycle.
  - start while busy is ignored.
- stop:
  - stop=1 in any state, next cycle: num=20'hFFFFF, busy=0, state=IDLE, no done pulse.
  - stop and start in the same cycle: stop wins.
- Writes:
  - Accepted in any state; buf[wr_addr] updated at the clock edge.
  - A write to the address read in the same step cycle: the old value is shifted in (read-before-write).
- len=0: four blank steps, then done. Total busy time 4*TICK_DIV cycles.
- Widths: step counter $clog2(MSG_LEN+4)+1 bits; prescaler $clog2(TICK_DIV) bits. No overflow is possible within a scroll.

Optional Feature:
- GLYPH_SCROLLER_LOOP_EN defined:
  - On the last step, the step counter resets to 0 and SCROLL continues, restarting the message after the 4-blank gap.
  - done pulses once per completed pass; busy stays 1 until stop or reset.
- Undefined: one-shot behaviour as above.

Decomposition:
- Package glyph_pkg:
  - GLYPH_W=5, GLYPH_BLANK=5'd31, GLYPH_DASH=5'd26, digit glyph constants 0-9.
  - Scroll state enum type.
- Sub-module scroll_tick (parameter TICK_DIV; ports clk, rst_n, clr, tick): prescaler emitting a one-cycle tick on wrap, cleared by clr.
- The buffer is an inline register array with one write port and one read port.

Test Plan (TICK_DIV=4, MSG_LEN=16):
- Reset sweep: hold rst_n=0 3 cycles → num=20'hFFFFF, busy=0, done=0.
- Basic scroll: write buf[0..2]={1,2,3}, msg_len=3, pulse start → busy=1 next cycle.
  - num after each step: {31,31,31,1}, {31,31,1,2}, {31,1,2,3}, {1,2,3,31}, {2,3,31,31}, {3,31,31,31}, {31,31,31,31}.
  - Steps occur every 4 cycles; done one cycle with busy falling; 28 cycles from start to done.
- Stop mid-scroll: start msg_len=3, assert stop after step 2 → num=20'hFFFFF, busy=0, done never pulses; a new start is accepted afterwards.
- Simultaneous start and stop in IDLE → stays IDLE, busy=0.
- Edge lengths:
  - msg_len=0 → 4 blank steps, done after 16 cycles.
  - msg_len=20 → clamped to 16; 20 steps; done after 80 cycles.
- Write collision: during SCROLL, write buf[1]=9 in the cycle step 1 shifts → old glyph appears; a rerun shows 9.
- With GLYPH_SCROLLER_LOOP_EN: msg_len=2 → done pulses every 24 cycles, busy stays 1 until stop.
